// File: rtl/bcd_to_hex_seq.sv
// rtl/bcd_to_hex_seq.sv - iterative BCD-to-binary converter (reverse double-dabble)
// Optional build macro BCD_TO_HEX_SATURATE_EN clamps an overflowing result to all ones.
module bcd_to_hex_seq #(
  parameter int DIGITS    = 3,
  parameter int BIN_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcdValue,
  output logic                  busy,
  output logic                  hexValid,
  output logic [BIN_WIDTH-1:0]  hexValue,
  output logic                  overflow,
  output logic                  digitError
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               r_state, w_state_next;
  logic [BCD_W-1:0]     r_bcd, w_bcd_next;
  logic [BIN_WIDTH-1:0] r_bin, w_bin_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic                 r_err, w_err_next;
  logic                 r_busy, w_busy_next;
  logic                 r_valid, w_valid_next;
  logic [BIN_WIDTH-1:0] r_hex, w_hex_next;
  logic                 r_ovf, w_ovf_next;
  logic                 r_derr, w_derr_next;

  logic [BCD_W+BIN_WIDTH-1:0] w_shifted;
  logic [BCD_W-1:0]           w_bcd_shift;
  logic [BCD_W-1:0]           w_bcd_corr;
  logic                       w_bad_digit;
  logic                       w_ovf_calc;

  assign w_shifted   = {r_bcd, r_bin} >> 1;
  assign w_bcd_shift = w_shifted[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
  assign w_ovf_calc  = (r_bcd != '0);

  // Halving a BCD number: a digit that received a carried-in 1 (weight 10/2=5) must lose 3.
  always_comb begin
    w_bcd_corr = w_bcd_shift;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_bcd_shift[4*i +: 4] >= 4'd8) begin
        w_bcd_corr[4*i +: 4] = w_bcd_shift[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    w_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcdValue[4*i +: 4] > 4'd9) begin
        w_bad_digit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_bcd_next   = r_bcd;
    w_bin_next   = r_bin;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_busy_next  = r_busy;
    w_valid_next = 1'b0;
    w_hex_next   = r_hex;
    w_ovf_next   = r_ovf;
    w_derr_next  = r_derr;
    case (r_state)
      IDLE: begin
        w_busy_next = 1'b0;
        if (start) begin
          w_bcd_next   = bcdValue;
          w_bin_next   = '0;
          w_cnt_next   = '0;
          w_err_next   = w_bad_digit;
          w_busy_next  = 1'b1;
          w_state_next = w_bad_digit ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        w_bcd_next = w_bcd_corr;
        w_bin_next = w_shifted[BIN_WIDTH-1:0];
        w_cnt_next = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(BIN_WIDTH - 1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        // Results land on the edge leaving DONE so the hexValid cycle is already IDLE.
        w_state_next = IDLE;
        w_valid_next = 1'b1;
        w_derr_next  = r_err;
        if (r_err) begin
          w_hex_next = '0;
          w_ovf_next = 1'b0;
        end else begin
          w_ovf_next = w_ovf_calc;
`ifdef BCD_TO_HEX_SATURATE_EN
          w_hex_next = w_ovf_calc ? {BIN_WIDTH{1'b1}} : r_bin;
`else
          w_hex_next = r_bin;
`endif
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_hex   <= '0;
      r_ovf   <= 1'b0;
      r_derr  <= 1'b0;
    end else begin
      r_bcd   <= w_bcd_next;
      r_bin   <= w_bin_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_busy  <= w_busy_next;
      r_valid <= w_valid_next;
      r_hex   <= w_hex_next;
      r_ovf   <= w_ovf_next;
      r_derr  <= w_derr_next;
    end
  end

  assign busy       = r_busy;
  assign hexValid   = r_valid;
  assign hexValue   = r_hex;
  assign overflow   = r_ovf;
  assign digitError = r_derr;

endmodule

// File: tb/tb_bcd_to_hex_seq.sv
// tb/tb_bcd_to_hex_seq.sv - randomized self-checking bench for bcd_to_hex_seq
module tb_bcd_to_hex_seq;

  logic        clk;
  logic        resetN;
  logic        start;
  logic [11:0] bcdValue;
  logic        busy;
  logic        hexValid;
  logic [7:0]  hexValue;
  logic        overflow;
  logic        digitError;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  bcd_to_hex_seq #(.DIGITS(3), .BIN_WIDTH(8)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start),
    .bcdValue   (bcdValue),
    .busy       (busy),
    .hexValid   (hexValid),
    .hexValue   (hexValue),
    .overflow   (overflow),
    .digitError (digitError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Decimal reading of the operand, then the documented output rules.
  task automatic ref_conv(input logic [11:0] b, output logic [7:0] hex, output logic ovf,
                          output logic derr);
    int d2, d1, d0, v;
    d2 = int'(b[11:8]);
    d1 = int'(b[7:4]);
    d0 = int'(b[3:0]);
    derr = (d2 > 9) || (d1 > 9) || (d0 > 9);
    v = d2 * 100 + d1 * 10 + d0;
    if (derr) begin
      hex = 8'h00;
      ovf = 1'b0;
    end else begin
      ovf = (v > 255);
`ifdef BCD_TO_HEX_SATURATE_EN
      hex = ovf ? 8'hFF : 8'(v);
`else
      hex = 8'(v % 256);
`endif
    end
  endtask

  // Starts from IDLE at #1 after an edge; returns edges from acceptance to hexValid.
  task automatic do_conv(input logic [11:0] b, output int lat, output logic bsy);
    start    = 1'b1;
    bcdValue = b;
    @(posedge clk); #1;
    start    = 1'b0;
    bcdValue = 12'($urandom);
    bsy = busy;
    lat = 0;
    while (!hexValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    resetN   = 1'b0;
    start    = 1'b0;
    bcdValue = 12'h000;
    #2;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (hexValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", hexValid); else n_pass++;
    n_checks++; if (hexValue !== 8'h00) $display("FAIL reset_hex: got %h want 00", hexValue); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else n_pass++;
    n_checks++; if (digitError !== 1'b0) $display("FAIL reset_derr: got %b want 0", digitError); else n_pass++;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [11:0] ops [4] = '{12'h255, 12'h256, 12'h999, 12'h1A5};
    int          lats[4] = '{9, 9, 9, 1};
    logic [7:0]  eh;
    logic        eo, ed, bsy;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      ref_conv(ops[i], eh, eo, ed);
      do_conv(ops[i], lat, bsy);
      n_checks++; if (bsy !== 1'b1) $display("FAIL dir_busy %h: got %b want 1", ops[i], bsy); else n_pass++;
      n_checks++; if (lat != lats[i]) $display("FAIL dir_latency %h: got %0d want %0d", ops[i], lat, lats[i]); else n_pass++;
      n_checks++; if (hexValue !== eh) $display("FAIL dir_hex %h: got %h want %h", ops[i], hexValue, eh); else n_pass++;
      n_checks++; if (overflow !== eo) $display("FAIL dir_ovf %h: got %b want %b", ops[i], overflow, eo); else n_pass++;
      n_checks++; if (digitError !== ed) $display("FAIL dir_derr %h: got %b want %b", ops[i], digitError, ed); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (hexValid !== 1'b0) $display("FAIL dir_pulse %h: got %b want 0", ops[i], hexValid); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [11:0] b;
    logic [7:0]  eh;
    logic        eo, ed, bsy;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      b = (i % 2 == 0) ? to_bcd(int'($urandom_range(0, 999))) : 12'($urandom);
      ref_conv(b, eh, eo, ed);
      do_conv(b, lat, bsy);
      n_checks++; if (lat != (ed ? 1 : 9)) $display("FAIL rnd_latency %h: got %0d want %0d", b, lat, ed ? 1 : 9); else n_pass++;
      n_checks++; if ({hexValue, overflow, digitError} !== {eh, eo, ed})
        $display("FAIL rnd_result %h: got %h/%b/%b want %h/%b/%b", b, hexValue, overflow, digitError, eh, eo, ed);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int t_prev, wait_n;
    bcdValue = to_bcd(0);
    start    = 1'b1;
    t_prev   = 0;
    for (int n = 0; n <= 255; n++) begin
      wait_n = 0;
      @(posedge clk); #1;
      while (!hexValid && wait_n < 20) begin
        @(posedge clk); #1;
        wait_n++;
      end
      n_checks++; if (hexValue !== 8'(n)) $display("FAIL b2b_hex %0d: got %h want %h", n, hexValue, 8'(n)); else n_pass++;
      if (n > 0) begin
        n_checks++; if (cyc - t_prev != 10) $display("FAIL b2b_spacing %0d: got %0d want 10", n, cyc - t_prev); else n_pass++;
      end
      t_prev = cyc;
      if (n == 255) start = 1'b0;
      else bcdValue = to_bcd(n + 1);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_ignore;
    int pulses;
    start    = 1'b1;
    bcdValue = 12'h123;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start    = 1'b1;
    bcdValue = 12'h045;
    repeat (2) @(posedge clk);
    #1;
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (hexValid) begin
        pulses++;
        n_checks++; if (hexValue !== 8'h7B) $display("FAIL busy_hex: got %h want 7b", hexValue); else n_pass++;
      end
    end
    n_checks++; if (pulses != 1) $display("FAIL busy_pulses: got %0d want 1", pulses); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int   pulses, lat;
    logic bsy;
    start    = 1'b1;
    bcdValue = 12'h200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetN = 1'b0;
    #1;
    n_checks++; if ({busy, hexValid, hexValue, overflow, digitError} !== 12'h000)
      $display("FAIL abort_outputs: got %b/%b/%h/%b/%b want all 0", busy, hexValid, hexValue, overflow, digitError);
    else n_pass++;
    @(posedge clk); #1 resetN = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (hexValid) pulses++;
    end
    n_checks++; if (pulses != 0) $display("FAIL abort_pulses: got %0d want 0", pulses); else n_pass++;
    do_conv(12'h010, lat, bsy);
    n_checks++; if (lat != 9) $display("FAIL abort_relat: got %0d want 9", lat); else n_pass++;
    n_checks++; if (hexValue !== 8'h0A) $display("FAIL abort_rehex: got %h want 0a", hexValue); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_hex_seq.md
Name: bcd_to_hex_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the existing combinational hex-to-BCD block.
- Converts a packed BCD operand to binary using reverse double-dabble: one bit per clock, with start/busy/valid handshake.
- Used where BCD values from the display/score path must become binary again (e.g. score compare, board-index arithmetic).
- Iterative rather than combinational to keep the LUT count flat as DIGITS grows.

Parameters:
- DIGITS, 3, number of BCD digits on bcdValue (input width 4*DIGITS).
- BIN_WIDTH, 8, width of binary result; also the number of shift cycles.

Ports:
- clk  input  1  system clock, rising edge.
- resetN  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcdValue  input  4*DIGITS  packed BCD operand, digit 0 in bits [3:0]; sampled on the accepting edge only.
- busy  output  1  high from the cycle after acceptance until the hexValid cycle inclusive.
- hexValid  output  1  one-cycle pulse; result and flags valid.
- hexValue  output  BIN_WIDTH  binary result; holds until the next hexValid.
- overflow  output  1  operand exceeds 2^BIN_WIDTH-1; updated with hexValid, then held.
- digitError  output  1  some input digit >9; updated with hexValid, then held.

Behaviour:
- Reset (async, resetN=0):
  - state=IDLE.
  - All outputs 0; internal shift register and counter 0.
  - Reset mid-conversion aborts it; no hexValid is produced.
- Internal register: {bcdReg[4*DIGITS-1:0], binReg[BIN_WIDTH-1:0]}. Cycle counter is $clog2(BIN_WIDTH+1) bits.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge: capture bcdValue into bcdReg, clear binReg and counter.
  - Compute the digit check (any nibble >9).
  - On error go to DONE with an error flag latched; otherwise go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, per edge:
  - Shift the concatenated register right 1 (bcdReg LSB enters binReg MSB).
  - Then, for each post-shift digit >=8, subtract 3 from that digit.
  - Increment the counter.
  - After BIN_WIDTH SHIFT edges, go to DONE.
- DONE, one cycle, outputs registered on entry:
  - hexValid=1.
  - hexValue = binReg.
  - overflow = (bcdReg != 0).
  - digitError = latched flag.
  - Next edge returns to IDLE; hexValid returns to 0.
- Digit-error path: hexValue=0, overflow=0, digitError=1. DONE is reached one edge after acceptance.
- Latency, valid operand: start accepted at edge k -> hexValid high after edge k+BIN_WIDTH+1, for exactly one cycle.
- Earliest next acceptance: the edge after hexValid, i.e. back-to-back throughput is BIN_WIDTH+2 cycles.
- start while busy (SHIFT/DONE): ignored, not queued; bcdValue changes while busy have no effect.
- start held high continuously: a new conversion is accepted at every return to IDLE.
- Overflow without saturation: hexValue = true value mod 2^BIN_WIDTH (the natural result of the algorithm).
- All arithmetic is unsigned. Digit correction never underflows, since a digit >=8 always exceeds 3.

Optional Feature:
- Macro: BCD_TO_HEX_SATURATE_EN.
- Defined: when overflow=1, hexValue is forced to all ones (2^BIN_WIDTH-1) at DONE.
- Undefined: hexValue is the modulo result.
- overflow and digitError behave identically in both builds; digit error still yields hexValue=0.

Test Plan:
- DIGITS=3, BIN_WIDTH=8:
  - bcdValue=12'h255, start pulse -> busy asserted; hexValid exactly 9 cycles after the accepting edge; hexValue=8'hFF, overflow=0, digitError=0.
  - Exhaustive 12'h000..12'h255 back-to-back, start held high -> each hexValue equals the decimal value; every hexValid spaced 10 cycles apart.
  - bcdValue=12'h256 -> overflow=1. hexValue=8'h00 without macro; 8'hFF with BCD_TO_HEX_SATURATE_EN.
  - bcdValue=12'h999 -> overflow=1. hexValue=8'hE7 (999 mod 256) without macro; 8'hFF with macro.
  - bcdValue=12'h1A5 -> hexValid 1 cycle after acceptance; digitError=1, hexValue=0, overflow=0.
- Robustness:
  - Start 12'h123, assert start and change bcdValue to 12'h045 mid-conversion -> single result 8'h7B; the second start is not queued.
  - Start 12'h200, drop resetN for 1 cycle at shift 4 -> all outputs 0 immediately and no hexValid. A new start 12'h010 afterwards yields 8'h0A.
